// File: rtl/mem_port_arbiter_if.sv
// Shared-RAM port bundle between the fetch/load-store requesters, the arbiter and the RAM.
// The arbiter connects through the slave modport; requesters plus RAM form the master side.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  logic                  IReq;
  logic [ADDR_WIDTH-1:0] IAddr;
  logic                  IReady;
  logic [DATA_WIDTH-1:0] IData;

  logic                  DReq;
  logic                  DWrite;
  logic [ADDR_WIDTH-1:0] DAddr;
  logic [DATA_WIDTH-1:0] DWData;
  logic                  DReady;
  logic [DATA_WIDTH-1:0] DRData;

  logic [ADDR_WIDTH-1:0] MemAddress;
  logic                  MemWrite;
  logic [DATA_WIDTH-1:0] MemWriteData;
  logic [DATA_WIDTH-1:0] MemReadData;

  logic [1:0]            Grant;

  modport slave (
    input  IReq, IAddr, DReq, DWrite, DAddr, DWData, MemReadData,
    output IReady, IData, DReady, DRData, MemAddress, MemWrite, MemWriteData, Grant
  );

  modport master (
    output IReq, IAddr, DReq, DWrite, DAddr, DWData, MemReadData,
    input  IReady, IData, DReady, DRData, MemAddress, MemWrite, MemWriteData, Grant
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter giving instruction fetch and load/store alternating access to one RAM port.
// Define MEM_ARB_STATS_EN to add saturating ConflictCount/StoreCount outputs.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic Clock,
  input  logic Reset,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] ConflictCount,
  output logic [15:0] StoreCount
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACC_I = 2'b01,
    ACC_D = 2'b10
  } state_t;

  state_t state, state_nxt;
  // Set when the data side holds the most recent grant, so fetch wins the next tie.
  logic last_d, last_d_nxt;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wd;

  logic                  i_vld_p1, d_vld_p1;
  logic [DATA_WIDTH-1:0] i_data_p1, d_data_p1;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      last_d <= 1'b1;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    case (state)
      IDLE: begin
        if (bus.IReq && (!bus.DReq || last_d)) begin
          state_nxt  = ACC_I;
          last_d_nxt = 1'b0;
        end else if (bus.DReq) begin
          state_nxt  = ACC_D;
          last_d_nxt = 1'b1;
        end
      end
      ACC_I:   state_nxt = IDLE;
      ACC_D:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM drive is purely a function of state, so reset removes MemWrite without waiting for an edge.
  always_comb begin
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_wd   = '0;
    case (state)
      ACC_I: mem_addr = bus.IAddr;
      ACC_D: begin
        mem_addr = bus.DAddr;
        mem_we   = bus.DWrite;
        mem_wd   = bus.DWData;
      end
      default: ;
    endcase
  end

  // ---- stage p1: capture RAM read data and raise the one-cycle Ready ----
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      i_vld_p1  <= 1'b0;
      d_vld_p1  <= 1'b0;
      i_data_p1 <= '0;
      d_data_p1 <= '0;
    end else begin
      i_vld_p1 <= (state == ACC_I);
      d_vld_p1 <= (state == ACC_D);
      if (state == ACC_I)
        i_data_p1 <= bus.MemReadData;
      if (state == ACC_D && !bus.DWrite)
        d_data_p1 <= bus.MemReadData;
    end
  end

  assign bus.MemAddress   = mem_addr;
  assign bus.MemWrite     = mem_we;
  assign bus.MemWriteData = mem_wd;
  assign bus.IReady       = i_vld_p1;
  assign bus.IData        = i_data_p1;
  assign bus.DReady       = d_vld_p1;
  assign bus.DRData       = d_data_p1;
  assign bus.Grant        = state;

`ifdef MEM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic conflict_seen, store_commit;
  assign conflict_seen = (state == IDLE) && bus.IReq && bus.DReq;
  assign store_commit  = (state == ACC_D) && bus.DWrite;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ConflictCount <= '0;
      StoreCount    <= '0;
    end else begin
      if (conflict_seen)
        ConflictCount <= sat_inc(ConflictCount);
      if (store_commit)
        StoreCount <= sat_inc(StoreCount);
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus hand sequences, scoreboarded read data.
// Also checks the MEM_ARB_STATS_EN counters when that macro is defined.
module tb_mem_port_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef MEM_ARB_STATS_EN
  logic [15:0] ConflictCount, StoreCount;
`endif

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
`ifdef MEM_ARB_STATS_EN
    ,
    .ConflictCount (ConflictCount),
    .StoreCount    (StoreCount)
`endif
  );

  logic [DW-1:0] ram    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  function automatic logic [DW-1:0] pat(input int a);
    if (a == 5) return 32'h2402000A;
    return 32'h5A00_0000 ^ (a * 32'h0001_0003);
  endfunction

  // RAM model: combinational read, write on the rising edge when MemWrite is high.
  assign bus.MemReadData = ram[bus.MemAddress];
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] <= pat(i);
    forever begin
      @(posedge Clock);
      if (bus.MemWrite) ram[bus.MemAddress] <= bus.MemWriteData;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  logic [DW-1:0] exp_i [$];
  logic [DW-1:0] exp_d [$];
  logic [DW-1:0] last_dr;

  // Scoreboard: each Ready pulse consumes the oldest expectation for its side.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (bus.IReady) begin
        if (exp_i.size() == 0) chk("iready_unexpected", 32'd1, 32'd0);
        else chk("idata", bus.IData, exp_i.pop_front());
      end
      if (bus.DReady) begin
        if (exp_d.size() == 0) chk("dready_unexpected", 32'd1, 32'd0);
        else chk("drdata", bus.DRData, exp_d.pop_front());
      end
    end
  end

  typedef struct {
    logic          is_d;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    exp_grant;
    logic          exp_mw;
  } vec_t;

  task automatic push_txn(input logic is_d, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd);
    if (!is_d) begin
      exp_i.push_back(shadow[a]);
    end else begin
      if (wr) shadow[a] = wd;
      else    last_dr   = shadow[a];
      exp_d.push_back(last_dr);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge Clock);
    if (v.is_d) begin
      bus.DReq = 1'b1; bus.DWrite = v.wr; bus.DAddr = v.addr; bus.DWData = v.wdata;
    end else begin
      bus.IReq = 1'b1; bus.IAddr = v.addr;
    end
    push_txn(v.is_d, v.wr, v.addr, v.wdata);
    @(posedge Clock); #1;
    chk("acc_grant", 32'(bus.Grant), 32'(v.exp_grant));
    chk("acc_memwrite", 32'(bus.MemWrite), 32'(v.exp_mw));
    chk("acc_memaddr", 32'(bus.MemAddress), 32'(v.addr));
    chk("acc_memwdata", bus.MemWriteData, (v.is_d && v.wr) ? v.wdata : 32'h0);
    @(posedge Clock); #1;
    chk("ready_side_i", 32'(bus.IReady), 32'(!v.is_d));
    chk("ready_side_d", 32'(bus.DReady), 32'(v.is_d));
    chk("ready_grant", 32'(bus.Grant), 32'd0);
    chk("ready_memwrite", 32'(bus.MemWrite), 32'd0);
    @(negedge Clock);
    bus.IReq = 1'b0; bus.DReq = 1'b0; bus.DWrite = 1'b0;
    @(posedge Clock); #1;
    chk("ready_cleared", 32'({bus.IReady, bus.DReady}), 32'd0);
    chk("idle_grant", 32'(bus.Grant), 32'd0);
  endtask

  vec_t vecs [9];
  logic [1:0] cg_grant [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
  logic       cg_ir    [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       cg_dr    [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    vecs[0] = '{1'b0, 1'b0, 14'd5,     32'h0,        2'b01, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 14'd100,   32'hDEADBEEF, 2'b10, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 14'd100,   32'h0,        2'b10, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 14'd16383, 32'h0,        2'b01, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 14'd16383, 32'hCAFEF00D, 2'b10, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 14'd16383, 32'h0,        2'b01, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 14'd0,     32'h0,        2'b10, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 14'd0,     32'h00000001, 2'b10, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 14'd0,     32'h0,        2'b01, 1'b0};

    for (int i = 0; i < (1 << AW); i++) shadow[i] = pat(i);
    last_dr = '0;
    bus.IReq = 1'b0; bus.IAddr = '0;
    bus.DReq = 1'b0; bus.DWrite = 1'b0; bus.DAddr = '0; bus.DWData = '0;

    repeat (2) @(posedge Clock);
    #1;
    chk("rst_grant", 32'(bus.Grant), 32'd0);
    chk("rst_ready", 32'({bus.IReady, bus.DReady}), 32'd0);
    chk("rst_idata", bus.IData, 32'h0);
    chk("rst_drdata", bus.DRData, 32'h0);
    chk("rst_memwrite", 32'(bus.MemWrite), 32'd0);

    // Both sides requesting from reset: I first, then strict alternation.
    bus.IReq = 1'b1; bus.IAddr = 14'd20;
    bus.DReq = 1'b1; bus.DAddr = 14'd30;
    for (int k = 0; k < 2; k++) begin
      push_txn(1'b0, 1'b0, 14'd20, 32'h0);
      push_txn(1'b1, 1'b0, 14'd30, 32'h0);
    end
    @(negedge Clock);
    Reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge Clock); #1;
      chk($sformatf("conf_grant_%0d", c), 32'(bus.Grant), 32'(cg_grant[c]));
      chk($sformatf("conf_iready_%0d", c), 32'(bus.IReady), 32'(cg_ir[c]));
      chk($sformatf("conf_dready_%0d", c), 32'(bus.DReady), 32'(cg_dr[c]));
    end
    @(negedge Clock);
    bus.IReq = 1'b0; bus.DReq = 1'b0;
    @(posedge Clock); #1;
    chk("conf_idle", 32'(bus.Grant), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Back-to-back loads: address changes during the DReady cycle.
    @(negedge Clock);
    bus.DReq = 1'b1; bus.DWrite = 1'b0; bus.DAddr = 14'd16383;
    push_txn(1'b1, 1'b0, 14'd16383, 32'h0);
    @(posedge Clock); #1;
    chk("b2b_grant1", 32'(bus.Grant), 32'd2);
    @(posedge Clock); #1;
    chk("b2b_ready1", 32'(bus.DReady), 32'd1);
    @(negedge Clock);
    bus.DAddr = 14'd100;
    push_txn(1'b1, 1'b0, 14'd100, 32'h0);
    @(posedge Clock); #1;
    chk("b2b_grant2", 32'(bus.Grant), 32'd2);
    chk("b2b_addr2", 32'(bus.MemAddress), 32'd100);
    chk("b2b_noready", 32'(bus.DReady), 32'd0);
    @(posedge Clock); #1;
    chk("b2b_ready2", 32'(bus.DReady), 32'd1);
    @(negedge Clock);
    bus.DReq = 1'b0;
    @(posedge Clock); #1;
    chk("b2b_idle", 32'(bus.Grant), 32'd0);

`ifdef MEM_ARB_STATS_EN
    chk("stats_conflicts", 32'(ConflictCount), 32'd4);
    chk("stats_stores", 32'(StoreCount), 32'd3);
`endif

    // Reset in the middle of a store's access cycle must suppress the write.
    @(negedge Clock);
    bus.DReq = 1'b1; bus.DWrite = 1'b1; bus.DAddr = 14'd7; bus.DWData = 32'h12345678;
    @(posedge Clock); #1;
    chk("mrst_acc_memwrite", 32'(bus.MemWrite), 32'd1);
    #1 Reset = 1'b1;
    #1;
    chk("mrst_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("mrst_grant", 32'(bus.Grant), 32'd0);
    chk("mrst_dready", 32'(bus.DReady), 32'd0);
    @(posedge Clock); #1;
    chk("mrst_dready_edge", 32'(bus.DReady), 32'd0);
    @(negedge Clock);
    bus.DReq = 1'b0; bus.DWrite = 1'b0;
    Reset = 1'b0;
    last_dr = '0;
    @(posedge Clock); #1;
    chk("mrst_idle", 32'(bus.Grant), 32'd0);
    chk("mrst_ram7", ram[7], shadow[7]);
    chk("mrst_drdata", bus.DRData, 32'h0);
`ifdef MEM_ARB_STATS_EN
    chk("stats_clr_conflicts", 32'(ConflictCount), 32'd0);
    chk("stats_clr_stores", 32'(StoreCount), 32'd0);
`endif
    run_vec('{1'b0, 1'b0, 14'd7, 32'h0, 2'b01, 1'b0});

    repeat (2) @(posedge Clock);
    chk("sb_i_empty", 32'(exp_i.size()), 32'd0);
    chk("sb_d_empty", 32'(exp_d.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
